// File: rtl/rl_desc_qm.sv
// rtl/rl_desc_qm.sv - per-application descriptor queue manager with PIFO notification
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_desc*             descriptor enqueue from the RX parser (valid/ready)
//   deq_req, deq_app_id dequeue strobe from the scheduler
//   m_desc*             one-cycle descriptor response, fixed latency 1
//   m_pifo_*            one notification (prio, app id) per accepted descriptor
//   queue_empty         registered per-app empty flags
//   err_empty_req       pulse when a request hits an empty queue
//   empty_req_cnt       saturating count of empty requests

`ifndef RL_DESC_APP_ID_SIZE
`define RL_DESC_APP_ID_SIZE 2
`endif

`ifndef RL_DESC_WIDTH
`define RL_DESC_WIDTH 32
`endif

module rl_desc_qm #(
    parameter int APP_ID_WIDTH = `RL_DESC_APP_ID_SIZE,
    parameter int APP_COUNT    = 2**APP_ID_WIDTH,
    parameter int DESC_WIDTH   = `RL_DESC_WIDTH,
    parameter int QUEUE_DEPTH  = 16,
    parameter int PTR_WIDTH    = $clog2(QUEUE_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DESC_WIDTH-1:0]   s_desc,
    input  logic [APP_ID_WIDTH-1:0] s_desc_app_id,
    input  logic [APP_ID_WIDTH-1:0] s_desc_prio,
    input  logic                    s_desc_valid,
    output logic                    s_desc_ready,
    input  logic                    deq_req,
    input  logic [APP_ID_WIDTH-1:0] deq_app_id,
    output logic [DESC_WIDTH-1:0]   m_desc,
    output logic                    m_desc_valid,
    output logic                    m_pifo_valid,
    output logic [APP_ID_WIDTH-1:0] m_pifo_prio,
    output logic [APP_ID_WIDTH-1:0] m_pifo_data,
    input  logic                    m_pifo_ready,
    output logic [APP_COUNT-1:0]    queue_empty,
    output logic                    err_empty_req,
    output logic [31:0]             empty_req_cnt
);

    localparam int ADDR_WIDTH = APP_ID_WIDTH + PTR_WIDTH;
    localparam int RAM_WORDS  = APP_COUNT * QUEUE_DEPTH;
    localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(QUEUE_DEPTH);

    logic [DESC_WIDTH-1:0] ram [RAM_WORDS];

    logic [PTR_WIDTH-1:0] head       [APP_COUNT];
    logic [PTR_WIDTH-1:0] tail       [APP_COUNT];
    logic [PTR_WIDTH:0]   count      [APP_COUNT];
    logic [PTR_WIDTH:0]   count_next [APP_COUNT];

    logic                  pifo_free;
    logic                  enq_fire;
    logic                  deq_hit;
    logic                  deq_miss;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // The notification register has a single slot, so an enqueue may only
    // proceed when that slot is empty or draining this cycle.
    assign pifo_free    = !m_pifo_valid || m_pifo_ready;
    assign s_desc_ready = !rst && (count[s_desc_app_id] != FULL_CNT) && pifo_free;
    assign enq_fire     = s_desc_valid && s_desc_ready;
    assign deq_hit      = !rst && deq_req && (count[deq_app_id] != '0);
    assign deq_miss     = !rst && deq_req && (count[deq_app_id] == '0);
    assign wr_addr      = {s_desc_app_id, tail[s_desc_app_id]};
    assign rd_addr      = {deq_app_id, head[deq_app_id]};

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ram[wr_addr] <= s_desc;
        end
    end

    // Separate read process: a same-edge write to the read address is not
    // yet visible here, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_desc <= '0;
        end else if (deq_hit) begin
            m_desc <= ram[rd_addr];
        end
    end

    always_comb begin
        for (int i = 0; i < APP_COUNT; i++) begin
            count_next[i] = count[i];
            if (enq_fire && (s_desc_app_id == APP_ID_WIDTH'(i))) begin
                count_next[i] = count_next[i] + 1'b1;
            end
            if (deq_hit && (deq_app_id == APP_ID_WIDTH'(i))) begin
                count_next[i] = count_next[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < APP_COUNT; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            queue_empty <= '1;
        end else begin
            for (int i = 0; i < APP_COUNT; i++) begin
                if (enq_fire && (s_desc_app_id == APP_ID_WIDTH'(i))) begin
                    tail[i] <= tail[i] + 1'b1;
                end
                if (deq_hit && (deq_app_id == APP_ID_WIDTH'(i))) begin
                    head[i] <= head[i] + 1'b1;
                end
                count[i]       <= count_next[i];
                queue_empty[i] <= (count_next[i] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_desc_valid  <= 1'b0;
            err_empty_req <= 1'b0;
            empty_req_cnt <= '0;
        end else begin
            m_desc_valid  <= deq_hit;
            err_empty_req <= deq_miss;
            if (deq_miss && (empty_req_cnt != 32'hFFFF_FFFF)) begin
                empty_req_cnt <= empty_req_cnt + 32'd1;
            end
        end
    end

    // A reload in the same cycle as a drain keeps valid high, sustaining
    // back-to-back enqueues while the PIFO is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_pifo_valid <= 1'b0;
            m_pifo_prio  <= '0;
            m_pifo_data  <= '0;
        end else if (enq_fire) begin
            m_pifo_valid <= 1'b1;
            m_pifo_prio  <= s_desc_prio;
            m_pifo_data  <= s_desc_app_id;
        end else if (m_pifo_ready) begin
            m_pifo_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rl_desc_qm.sv
// tb/tb_rl_desc_qm.sv - self-checking bench for rl_desc_qm

module tb_rl_desc_qm;

    logic        clk;
    logic        rst;
    logic [31:0] s_desc;
    logic [1:0]  s_desc_app_id;
    logic [1:0]  s_desc_prio;
    logic        s_desc_valid;
    logic        s_desc_ready;
    logic        deq_req;
    logic [1:0]  deq_app_id;
    logic [31:0] m_desc;
    logic        m_desc_valid;
    logic        m_pifo_valid;
    logic [1:0]  m_pifo_prio;
    logic [1:0]  m_pifo_data;
    logic        m_pifo_ready;
    logic [3:0]  queue_empty;
    logic        err_empty_req;
    logic [31:0] empty_req_cnt;

    int checks;
    int failures;

    rl_desc_qm dut (
        .clk           (clk),
        .rst           (rst),
        .s_desc        (s_desc),
        .s_desc_app_id (s_desc_app_id),
        .s_desc_prio   (s_desc_prio),
        .s_desc_valid  (s_desc_valid),
        .s_desc_ready  (s_desc_ready),
        .deq_req       (deq_req),
        .deq_app_id    (deq_app_id),
        .m_desc        (m_desc),
        .m_desc_valid  (m_desc_valid),
        .m_pifo_valid  (m_pifo_valid),
        .m_pifo_prio   (m_pifo_prio),
        .m_pifo_data   (m_pifo_data),
        .m_pifo_ready  (m_pifo_ready),
        .queue_empty   (queue_empty),
        .err_empty_req (err_empty_req),
        .empty_req_cnt (empty_req_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [1:0]  app;
        logic [1:0]  prio;
        logic [31:0] d;
        logic        dq;
        logic [1:0]  dapp;
        logic        pr;
        logic        e_rdy;
        logic        e_mdv;
        logic [31:0] e_mdesc;
        logic        e_pv;
        logic [1:0]  e_pprio;
        logic [1:0]  e_pdata;
        logic [3:0]  e_qe;
    } vec_t;

    localparam logic [31:0] DA0 = 32'hA000_0000;
    localparam logic [31:0] DA1 = 32'hA000_0001;
    localparam logic [31:0] DA2 = 32'hA000_0002;
    localparam logic [31:0] DB0 = 32'hB000_0000;
    localparam logic [31:0] DB1 = 32'hB000_0001;
    localparam logic [31:0] DB9 = 32'hB000_0009;
    localparam logic [31:0] DC0 = 32'hC000_0000;
    localparam logic [31:0] DC1 = 32'hC000_0001;

    vec_t        tbl [22];
    logic [31:0] sb [$];
    logic [31:0] exp_d;

    function automatic vec_t mk(int v, int app, int prio, logic [31:0] d, int dq, int dapp,
                                int pr, int rdy, int mdv, logic [31:0] md, int pv, int pp,
                                int pd, int qe);
        vec_t r;
        r.v = 1'(v);   r.app = 2'(app);   r.prio = 2'(prio); r.d = d;
        r.dq = 1'(dq); r.dapp = 2'(dapp); r.pr = 1'(pr);
        r.e_rdy = 1'(rdy); r.e_mdv = 1'(mdv); r.e_mdesc = md;
        r.e_pv = 1'(pv); r.e_pprio = 2'(pp); r.e_pdata = 2'(pd); r.e_qe = 4'(qe);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks run at the next
    // falling edge, before the edge that consumes these inputs.
    task automatic drive(input int r, input int v, input int app, input int prio,
                         input logic [31:0] d, input int dq, input int dapp, input int pr);
        @(posedge clk);
        #1;
        rst           = 1'(r);
        s_desc_valid  = 1'(v);
        s_desc_app_id = 2'(app);
        s_desc_prio   = 2'(prio);
        s_desc        = d;
        deq_req       = 1'(dq);
        deq_app_id    = 2'(dapp);
        m_pifo_ready  = 1'(pr);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; s_desc_valid = 1'b0; s_desc_app_id = '0; s_desc_prio = '0;
        s_desc = '0; deq_req = 1'b0; deq_app_id = '0; m_pifo_ready = 1'b1;

        // ---- reset state
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_rdy", s_desc_ready, 0);
        chk("rst_mdv", m_desc_valid, 0);
        chk("rst_mdesc", m_desc, 0);
        chk("rst_pv", m_pifo_valid, 0);
        chk("rst_qe", queue_empty, 4'hF);
        chk("rst_err", err_empty_req, 0);
        chk("rst_cnt", empty_req_cnt, 0);

        // ---- table: FIFO order, same-cycle enq/deq, PIFO backpressure
        tbl[0]  = mk(1,2,1,DA0, 0,0,1, 1,0,0,   0,0,0, 4'hF);
        tbl[1]  = mk(1,2,1,DA1, 0,0,1, 1,0,0,   1,1,2, 4'hB);
        tbl[2]  = mk(1,2,1,DA2, 0,0,1, 1,0,0,   1,1,2, 4'hB);
        tbl[3]  = mk(0,2,0,0,   1,2,1, 1,0,0,   1,1,2, 4'hB);
        tbl[4]  = mk(0,2,0,0,   1,2,1, 1,1,DA0, 0,0,0, 4'hB);
        tbl[5]  = mk(0,2,0,0,   1,2,1, 1,1,DA1, 0,0,0, 4'hB);
        tbl[6]  = mk(0,2,0,0,   0,0,1, 1,1,DA2, 0,0,0, 4'hF);
        tbl[7]  = mk(0,0,0,0,   0,0,1, 1,0,0,   0,0,0, 4'hF);
        tbl[8]  = mk(1,0,3,DB0, 0,0,1, 1,0,0,   0,0,0, 4'hF);
        tbl[9]  = mk(1,0,3,DB1, 0,0,1, 1,0,0,   1,3,0, 4'hE);
        tbl[10] = mk(1,0,3,DB9, 1,0,1, 1,0,0,   1,3,0, 4'hE);
        tbl[11] = mk(0,0,0,0,   1,0,1, 1,1,DB0, 1,3,0, 4'hE);
        tbl[12] = mk(0,0,0,0,   1,0,1, 1,1,DB1, 0,0,0, 4'hE);
        tbl[13] = mk(0,0,0,0,   0,0,1, 1,1,DB9, 0,0,0, 4'hF);
        tbl[14] = mk(1,3,2,DC0, 0,0,1, 1,0,0,   0,0,0, 4'hF);
        tbl[15] = mk(1,3,1,DC1, 0,0,0, 0,0,0,   1,2,3, 4'h7);
        tbl[16] = mk(1,3,1,DC1, 0,0,0, 0,0,0,   1,2,3, 4'h7);
        tbl[17] = mk(1,3,1,DC1, 0,0,1, 1,0,0,   1,2,3, 4'h7);
        tbl[18] = mk(0,3,0,0,   0,0,1, 1,0,0,   1,1,3, 4'h7);
        tbl[19] = mk(0,3,0,0,   1,3,1, 1,0,0,   0,0,0, 4'h7);
        tbl[20] = mk(0,3,0,0,   1,3,1, 1,1,DC0, 0,0,0, 4'h7);
        tbl[21] = mk(0,3,0,0,   0,0,1, 1,1,DC1, 0,0,0, 4'hF);

        for (int i = 0; i < 22; i++) begin
            drive(0, int'(tbl[i].v), int'(tbl[i].app), int'(tbl[i].prio), tbl[i].d,
                  int'(tbl[i].dq), int'(tbl[i].dapp), int'(tbl[i].pr));
            chk($sformatf("row%0d_rdy", i), s_desc_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d_mdv", i), m_desc_valid, tbl[i].e_mdv);
            if (tbl[i].e_mdv) chk($sformatf("row%0d_mdesc", i), m_desc, tbl[i].e_mdesc);
            chk($sformatf("row%0d_pv", i), m_pifo_valid, tbl[i].e_pv);
            if (tbl[i].e_pv) begin
                chk($sformatf("row%0d_pprio", i), m_pifo_prio, tbl[i].e_pprio);
                chk($sformatf("row%0d_pdata", i), m_pifo_data, tbl[i].e_pdata);
            end
            chk($sformatf("row%0d_qe", i), queue_empty, tbl[i].e_qe);
            chk($sformatf("row%0d_err", i), err_empty_req, 0);
        end

        // ---- fill app 1, full blocks only app 1, then wrap over 40 descriptors
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 0, 32'h100 + i, 0, 0, 1);
            chk($sformatf("fill%0d_rdy", i), s_desc_ready, 1);
            sb.push_back(32'h100 + i);
        end
        drive(0, 1, 1, 0, 32'hDEAD, 0, 0, 1);
        chk("full_app1_rdy", s_desc_ready, 0);
        drive(0, 1, 0, 0, 32'hD0, 0, 0, 1);
        chk("full_app0_rdy", s_desc_ready, 1);
        chk("full_qe", queue_empty, 4'hD);
        drive(0, 0, 1, 0, 0, 1, 1, 1);
        for (int k = 0; k < 24; k++) begin
            drive(0, 1, 1, 0, 32'h110 + k, 1, 1, 1);
            chk($sformatf("wrap%0d_rdy", k), s_desc_ready, 1);
            exp_d = sb.pop_front();
            chk($sformatf("wrap%0d_mdv", k), m_desc_valid, 1);
            chk($sformatf("wrap%0d_mdesc", k), m_desc, exp_d);
            sb.push_back(32'h110 + k);
        end
        for (int k = 0; k < 16; k++) begin
            if (k < 15) drive(0, 0, 1, 0, 0, 1, 1, 1);
            else        drive(0, 0, 1, 0, 0, 0, 0, 1);
            exp_d = sb.pop_front();
            chk($sformatf("drain%0d_mdv", k), m_desc_valid, 1);
            chk($sformatf("drain%0d_mdesc", k), m_desc, exp_d);
        end
        chk("drain_qe", queue_empty, 4'hE);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("app0_mdv", m_desc_valid, 1);
        chk("app0_mdesc", m_desc, 32'hD0);
        chk("app0_qe", queue_empty, 4'hF);

        // ---- empty requests
        drive(0, 0, 0, 0, 0, 1, 3, 1);
        chk("empty_pre_err", err_empty_req, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("empty_err", err_empty_req, 1);
        chk("empty_mdv", m_desc_valid, 0);
        chk("empty_cnt1", empty_req_cnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("empty_err_clr", err_empty_req, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 1, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("empty_cnt5", empty_req_cnt, 5);
        chk("empty_err5", err_empty_req, 1);
        chk("empty_mdv5", m_desc_valid, 0);

        // ---- reset with entries queued and a dequeue issued in the reset cycle
        drive(0, 1, 2, 0, 32'hE0, 0, 0, 1);
        drive(0, 1, 2, 0, 32'hE1, 0, 0, 1);
        drive(0, 1, 2, 0, 32'hE2, 0, 0, 1);
        drive(1, 0, 2, 0, 0, 1, 2, 1);
        chk("mrst_rdy", s_desc_ready, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("mrst_mdv", m_desc_valid, 0);
        chk("mrst_mdesc", m_desc, 0);
        chk("mrst_qe", queue_empty, 4'hF);
        chk("mrst_cnt", empty_req_cnt, 0);
        chk("mrst_pv", m_pifo_valid, 0);
        drive(0, 1, 1, 2, 32'h5, 0, 0, 1);
        chk("post_rdy", s_desc_ready, 1);
        chk("post_mdv0", m_desc_valid, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 1);
        chk("post_pv", m_pifo_valid, 1);
        chk("post_pdata", m_pifo_data, 1);
        chk("post_pprio", m_pifo_prio, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_mdv", m_desc_valid, 1);
        chk("post_mdesc", m_desc, 32'h5);
        chk("post_qe", queue_empty, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rl_desc_qm.md
Name: rl_desc_qm

Overview:
- Per-application descriptor queue manager.
- Answers the scheduler's descriptor requests (req + app_id in, descriptor + valid out).
- Accepts descriptors from the RX parser into per-app FIFOs carved from one shared RAM.
- Emits one PIFO notification (prio, app_id) per accepted descriptor, so the scheduler's PIFO holds exactly one token per queued descriptor.

Parameters:
- APP_ID_WIDTH, `RL_DESC_APP_ID_SIZE: width of app id and priority fields.
- APP_COUNT, 2**APP_ID_WIDTH: number of per-app queues.
- DESC_WIDTH, `RL_DESC_WIDTH: descriptor width.
- QUEUE_DEPTH, 16: entries per app queue. Must be a power of two, ≥2.
- PTR_WIDTH, $clog2(QUEUE_DEPTH): head/tail pointer width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_desc  in  DESC_WIDTH  descriptor to enqueue.
- s_desc_app_id  in  APP_ID_WIDTH  target queue.
- s_desc_prio  in  APP_ID_WIDTH  priority forwarded to PIFO.
- s_desc_valid  in  1  enqueue valid.
- s_desc_ready  out  1  enqueue ready.
- deq_req  in  1  dequeue request strobe from scheduler.
- deq_app_id  in  APP_ID_WIDTH  queue to dequeue.
- m_desc  out  DESC_WIDTH  returned descriptor.
- m_desc_valid  out  1  one-cycle response pulse.
- m_pifo_valid  out  1  notification valid.
- m_pifo_prio  out  APP_ID_WIDTH  notification priority.
- m_pifo_data  out  APP_ID_WIDTH  notification app id.
- m_pifo_ready  in  1  notification ready.
- queue_empty  out  APP_COUNT  bit i = queue i count==0, registered.
- err_empty_req  out  1  pulse: request hit an empty queue.
- empty_req_cnt  out  32  saturating count of empty requests.

Behaviour:
- Storage: one RAM of APP_COUNT*QUEUE_DEPTH words.
  - Address = {app_id, ptr}.
  - Registered read port, one write port.
- Per-app state: head[PTR_WIDTH], tail[PTR_WIDTH], count[PTR_WIDTH+1].
  - Pointers wrap modulo QUEUE_DEPTH.
- Enqueue: s_desc_ready = (count[s_desc_app_id] != QUEUE_DEPTH) && (!m_pifo_valid || m_pifo_ready).
  - s_desc_ready is combinational on s_desc_app_id; a sender must not change app_id while valid.
  - On s_desc_valid && s_desc_ready:
    - Write RAM[{app,tail}].
    - tail++, count++.
    - Load m_pifo_valid=1, m_pifo_prio=s_desc_prio, m_pifo_data=s_desc_app_id at the next edge.
- Notification register: m_pifo_valid clears on m_pifo_ready unless it is reloaded in the same cycle.
  - Back-to-back enqueues are sustained while m_pifo_ready=1.
- Dequeue: deq_req in cycle N with count[deq_app_id] (pre-cycle value) != 0:
  - RAM read of {app,head}; head++, count-- at edge N.
  - m_desc_valid=1 with data in cycle N+1.
  - Latency is fixed at 1 and there is no response backpressure: the requester gates deq_req with its own downstream ready.
- Empty request: deq_req with pre-cycle count==0.
  - No RAM access, no pointer change, m_desc_valid stays 0.
  - err_empty_req=1 in cycle N+1.
  - empty_req_cnt increments and saturates at 0xFFFFFFFF.
- Simultaneous enqueue and dequeue, same app, count≠0:
  - Both take effect; count unchanged.
  - If the write and read address match (count==1 wrap case is impossible because head≠tail when count≥1 and the queue is not full), RAM must return the old data (read-first).
- Simultaneous enqueue and dequeue, same app, count==0: enqueue accepted, dequeue treated as an empty request.
- Simultaneous enqueue and dequeue, same app, count==QUEUE_DEPTH: enqueue is blocked by ready; dequeue proceeds.
- Simultaneous enqueue and dequeue, different apps: fully independent.
- Full queue: blocks only its own app; other apps are still accepted.
- Reset (any cycle, including mid-operation):
  - All head/tail/count cleared to 0.
  - m_desc_valid=0, m_pifo_valid=0, m_pifo_prio=0, m_pifo_data=0, err_empty_req=0, empty_req_cnt=0, queue_empty=all ones.
  - m_desc=0; RAM contents undefined.
  - s_desc_ready is 0 during reset.
  - An in-flight response is discarded.
- queue_empty reflects post-edge counts (registered).

Test Plan:
- Enqueue D0,D1,D2 to app 2 (prio 1), then deq_req app 2 three consecutive cycles.
  - Required: m_pifo sees (1,2) three times.
  - Required: m_desc D0,D1,D2 each exactly 1 cycle after its req.
  - Required: queue_empty[2] returns to 1.
- Fill app 1 with 16 descriptors.
  - Required: s_desc_ready=0 for app 1 while app 0 enqueue is accepted.
  - After one deq of app 1, required: 17th enqueue accepted and tail wraps to 0; order preserved across the wrap over 40 descriptors.
- deq_req app 3 while empty.
  - Required: m_desc_valid=0, err_empty_req pulses in N+1, empty_req_cnt=1.
  - Repeat 5 times; required: empty_req_cnt=5.
- App 0 holding 2 entries; enqueue D9 and deq_req app 0 in the same cycle.
  - Required: oldest entry returned, count stays 2, D9 returned third.
- Hold m_pifo_ready=0 with one notification pending.
  - Required: s_desc_ready=0, no enqueue accepted, m_pifo_* stable.
  - Release; required: the pending notification drains and the next enqueue proceeds the same cycle.
- Assert rst with 3 entries queued and a dequeue in flight.
  - Required: no m_desc_valid after reset, all queue_empty=1, counter=0.
  - Post-reset enqueue/dequeue of D5 on app 1 returns D5.
